// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: WIDTH-bit a+b or a-b, DIGIT bits per clock,
// one DIGIT-bit ripple slice with a registered carry between digits.
// Params: WIDTH (operand width), DIGIT (bits per cycle, divides WIDTH).
// Ports : clk, rst_n (async, active-low), start/sub/a/b (sampled when
//         busy=0), busy, done (1-cycle pulse), sum, c_out (sub: 1=no borrow),
//         ovf (signed overflow).
// Macro : ADDSUB_OVF_EN builds the ovf flag; otherwise ovf is tied to 0.
module digit_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             load;
  logic             step;
  logic             last;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   dsum;

  logic [WIDTH-1:0] sum_q;
  logic             c_q;

  // One DIGIT-bit slice; the top bit is the carry into the next digit.
  assign dsum = {1'b0, op_a[DIGIT-1:0]}
              + {1'b0, op_b[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry};

  // New digit enters at the MSB end, so after NDIG steps the
  // least significant digit has reached bit 0.
  assign acc_nxt = (acc >> DIGIT)
                 | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

  assign last = (cnt == CW'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum_q <= '0;
      c_q   <= 1'b0;
    end else if (load) begin
      // Subtraction as a + ~b + 1: the +1 rides in on the carry.
      op_a  <= a;
      op_b  <= b ^ {WIDTH{sub}};
      carry <= sub;
      cnt   <= '0;
    end else if (step) begin
      op_a  <= op_a >> DIGIT;
      op_b  <= op_b >> DIGIT;
      acc   <= acc_nxt;
      carry <= dsum[DIGIT];
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum_q <= acc_nxt;
        c_q   <= dsum[DIGIT];
      end
    end
  end

`ifdef ADDSUB_OVF_EN
  logic cin_msb;
  logic ovf_q;

  // Carry into the top bit recovered from its sum bit and operand bits.
  assign cin_msb = dsum[DIGIT-1] ^ op_a[DIGIT-1] ^ op_b[DIGIT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (step && last) begin
      ovf_q <= cin_msb ^ dsum[DIGIT];
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy  = (state == S_RUN);
  assign done  = (state == S_DONE);
  assign sum   = sum_q;
  assign c_out = c_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Scoreboard bench for digit_serial_addsub at DIGIT=4, 1 and 16.
// Directed vectors with hand-computed results; a monitor checks each done.
module tb_digit_serial_addsub;

  localparam int W = 16;
`ifdef ADDSUB_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   start_v = '0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   busy_v;
  logic [2:0]   done_v;
  logic [2:0]   c_v;
  logic [2:0]   ovf_v;
  logic [W-1:0] sum_v [3];

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  vec_t vt[5];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  digit_serial_addsub #(.WIDTH(W), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub),
    .a(a), .b(b), .busy(busy_v[0]), .done(done_v[0]),
    .sum(sum_v[0]), .c_out(c_v[0]), .ovf(ovf_v[0])
  );

  digit_serial_addsub #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub),
    .a(a), .b(b), .busy(busy_v[1]), .done(done_v[1]),
    .sum(sum_v[1]), .c_out(c_v[1]), .ovf(ovf_v[1])
  );

  digit_serial_addsub #(.WIDTH(W), .DIGIT(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub),
    .a(a), .b(b), .busy(busy_v[2]), .done(done_v[2]),
    .sum(sum_v[2]), .c_out(c_v[2]), .ovf(ovf_v[2])
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(int k, vec_t v);
    exp_t e;
    e.s = v.s;
    e.c = v.c;
    e.o = OVF_ON ? v.o : 1'b0;
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    int   n;
    for (int k = 0; k < 3; k++) begin
      if (done_v[k]) begin
        n = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
        if (n == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_done dut%0d: got done=1 expected none", k);
        end else begin
          case (k)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
          endcase
          chk($sformatf("sum_dut%0d", k), 32'(sum_v[k]), 32'(e.s));
          chk($sformatf("c_out_dut%0d", k), 32'(c_v[k]), 32'(e.c));
          chk($sformatf("ovf_dut%0d", k), 32'(ovf_v[k]), 32'(e.o));
        end
      end
    end
  end

  task automatic wait_done(int k, output int n);
    n = 0;
    while (!done_v[k] && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!done_v[k]) begin
      checks++;
      failures++;
      $display("FAIL timeout_dut%0d: got no done expected done", k);
    end
  endtask

  task automatic run_op(int k, vec_t v, int ndig);
    int n;
    @(negedge clk);
    a = v.a;
    b = v.b;
    sub = v.sub;
    push(k, v);
    start_v[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[k] = 1'b0;
    chk($sformatf("busy_run_dut%0d", k), 32'(busy_v[k]), 32'd1);
    wait_done(k, n);
    chk($sformatf("latency_dut%0d", k), n, ndig);
    chk($sformatf("busy_done_dut%0d", k), 32'(busy_v[k]), 32'd0);
  endtask

  initial begin
    int n;
    int nd [3];
    nd[0] = 4;
    nd[1] = 16;
    nd[2] = 1;
    vt[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[4] = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_busy_dut%0d", k), 32'(busy_v[k]), 32'd0);
      chk($sformatf("rst_done_dut%0d", k), 32'(done_v[k]), 32'd0);
      chk($sformatf("rst_sum_dut%0d", k), 32'(sum_v[k]), 32'd0);
      chk($sformatf("rst_c_dut%0d", k), 32'(c_v[k]), 32'd0);
      chk($sformatf("rst_ovf_dut%0d", k), 32'(ovf_v[k]), 32'd0);
    end
    rst_n = 1'b1;

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 5; i++) begin
        run_op(k, vt[i], nd[k]);
      end
    end

    // Restart ignored while busy; held start chains straight from DONE.
    @(negedge clk);
    a = vt[0].a;
    b = vt[0].b;
    sub = vt[0].sub;
    push(0, vt[0]);
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    a = vt[2].a;
    b = vt[2].b;
    sub = vt[2].sub;
    push(0, vt[2]);
    start_v[0] = 1'b1;
    wait_done(0, n);
    chk("first_done_latency", n, 3);
    @(negedge clk);
    chk("b2b_busy_no_idle", 32'(busy_v[0]), 32'd1);
    start_v[0] = 1'b0;
    wait_done(0, n);
    chk("b2b_done_gap", n + 1, 5);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    a = 16'h1111;
    b = 16'h2222;
    sub = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_v[0]), 32'd0);
    chk("arst_done", 32'(done_v[0]), 32'd0);
    chk("arst_sum", 32'(sum_v[0]), 32'd0);
    chk("arst_c_out", 32'(c_v[0]), 32'd0);
    chk("arst_ovf", 32'(ovf_v[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("arst_no_done", 32'(done_v[0]), 32'd0);
    run_op(0, vt[4], 4);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", q0.size() + q1.size() + q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/digit_serial_addsub.md
Name: digit_serial_addsub

Overview:
Parametrised, multi-cycle adder/subtractor that processes WIDTH-bit operands DIGIT bits per clock using a single DIGIT-bit ripple slice with a registered carry. It is the area-lean successor to the single-bit full adder cell and adds subtraction, a start/done handshake and multi-cycle sequencing. It serves datapaths where operand width exceeds the area budget of a full-width adder and throughput of one result per WIDTH/DIGIT cycles is acceptable.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH.
(derived) NDIG = WIDTH/DIGIT, the number of digit cycles per operation.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when busy=0
sub  input  1  0: a+b, 1: a-b; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  result; holds until the next completion
c_out  output  1  carry out of MSB; for sub, 1 = no borrow
ovf  output  1  signed overflow (see Optional Feature)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: state=IDLE; busy, done, c_out and ovf = 0; sum = 0; internal shift registers, carry and digit counter = 0.
- FSM states:
  - IDLE: busy=0. On start=1, go to RUN.
  - RUN: busy=1. Processes one digit per edge.
  - DONE: busy=0, done=1 for exactly this cycle.
- IDLE -> RUN on the start edge (E0):
  - load opA=a and opB = sub ? ~b : b.
  - load carry=sub and cnt=0.
- RUN, each edge:
  - {c, s} = opA[DIGIT-1:0] + opB[DIGIT-1:0] + carry (DIGIT+1-bit arithmetic).
  - opA and opB shift right by DIGIT.
  - s shifts into the MSB end of the result shift register.
  - carry=c, cnt=cnt+1.
- RUN -> DONE on the edge where cnt==NDIG-1 (edge E_NDIG):
  - sum is loaded with the completed result and c_out with the final carry.
  - done=1 and busy=0 are visible in the cycle after E_NDIG.
  - Latency: start sampled at E0, done high after edge E0+NDIG.
- DONE exits:
  - start=1: go directly to RUN with a new load (back-to-back throughput of one result per NDIG+1 cycles).
  - otherwise: go to IDLE.
- start while busy=1: ignored; operands are not re-sampled; no error is flagged.
- sum and c_out change only on completion. They never show partial results.
- DIGIT==WIDTH: NDIG=1; done occurs one edge after start.
- DIGIT==1: pure bit-serial operation.
- Reset asserted mid-operation: the operation aborts immediately, all outputs return to reset values, and no done is issued.
- Arithmetic is modulo 2^WIDTH. Example: for a-b with a<b, sum = two's complement of the difference and c_out=0.

Optional Feature:
Macro ADDSUB_OVF_EN.
- Defined:
  - the carry into the MSB of the final digit is captured.
  - ovf = carry_into_MSB XOR c_out; it is loaded with sum at completion.
  - ovf is cleared by reset and held otherwise.
- Undefined: ovf is tied to 0 and no extra logic is built. The port list is identical in both builds.

Test Plan:
1. WIDTH=16, DIGIT=4: start with sub=0, a=0x1234, b=0x4321 -> busy high 4 cycles; done pulses 4 edges after start; sum=0x5555, c_out=0.
2. Add a=0xFFFF, b=0x0001 -> sum=0x0000, c_out=1; with ADDSUB_OVF_EN, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, c_out=0, ovf=1 (ovf=0 without the macro).
3. Subtract, sub=1: a=0x0005, b=0x0007 -> sum=0xFFFE, c_out=0. Then a=0x0007, b=0x0005 -> sum=0x0002, c_out=1.
4. Pulse start again 2 cycles into an operation with different operands -> ignored; first result is delivered unchanged. Hold start high through DONE -> second operation begins with no IDLE cycle; done pulses 5 cycles apart.
5. Drop rst_n 2 cycles into an operation -> busy, done, sum, c_out and ovf are 0 immediately (asynchronously); no done pulse. After release, a new start completes normally.
6. Re-run scenarios 1-3 with DIGIT=1 (done at +16 edges) and DIGIT=16 (done at +1 edge) -> identical sum, c_out and ovf values.
